// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//
// Program-counter and hardware call-stack stage. Holds the address of the
// current instruction, advances it on every enabled cycle and applies the
// jump / call / ret / skip requests coming from decode. Call and ret use an
// internal LIFO of return addresses. A stack overflow or underflow moves the
// block into a sticky HALT state that freezes pc, sp, the stack and fault
// until reset.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   en           in   advance enable; 0 stalls the stage (requests dropped)
//   jump         in   absolute jump to target
//   call         in   push pc+1, then jump to target
//   ret          in   pop return address into pc
//   skip         in   skip next instruction (pc += 2)
//   target       in   jump/call destination [PC_WIDTH]
//   pc           out  current instruction address (registered)
//   sp           out  number of valid stack entries [SP_WIDTH]
//   stack_full   out  sp == STACK_DEPTH
//   stack_empty  out  sp == 0
//   halted       out  block is in HALT
//   fault        out  0 none, 1 overflow, 2 underflow (3 never driven)
//
// Request priority when running and enabled: ret > call > jump > skip >
// sequential. All outputs come from registers or decode of registers only.
// -----------------------------------------------------------------------------
module prog_counter #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                jump,
    input  logic                call,
    input  logic                ret,
    input  logic                skip,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [SP_WIDTH-1:0] sp,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                halted,
    output logic [1:0]          fault
);

    // Index width for the return-address array; sp itself needs one extra
    // code to represent "full", the array index never does.
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_OVER  = 2'd1;
    localparam logic [1:0] FAULT_UNDER = 2'd2;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

    logic                active;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] skip_pc;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    push_idx;

    logic [PC_WIDTH-1:0] pc_next;
    logic [SP_WIDTH-1:0] sp_next;
    logic [1:0]          fault_next;
    logic                push;

    assign stack_full  = (sp == SP_WIDTH'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // An operation is only ever taken while running and enabled.
    assign active  = (state == RUN) && en;

    // Address arithmetic wraps naturally at PC_WIDTH bits.
    assign seq_pc  = pc + PC_WIDTH'(1);
    assign skip_pc = pc + PC_WIDTH'(2);

    // top_idx is only used when the stack is non-empty and push_idx only
    // when it is non-full, so both always fit the array index range.
    assign top_idx  = IDX_W'(sp - SP_WIDTH'(1));
    assign push_idx = IDX_W'(sp);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        if (active) begin
            if (ret) begin
                if (stack_empty) begin
                    state_next = HALT;
                end
            end else if (call && stack_full) begin
                state_next = HALT;
            end
        end
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        halted = (state == HALT);
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        pc_next    = pc;
        sp_next    = sp;
        fault_next = fault;
        push       = 1'b0;
        if (active) begin
            if (ret) begin
                if (stack_empty) begin
                    fault_next = FAULT_UNDER;
                end else begin
                    pc_next = stack[top_idx];
                    sp_next = sp - SP_WIDTH'(1);
                end
            end else if (call) begin
                if (stack_full) begin
                    fault_next = FAULT_OVER;
                end else begin
                    push    = 1'b1;
                    pc_next = target;
                    sp_next = sp + SP_WIDTH'(1);
                end
            end else if (jump) begin
                pc_next = target;
            end else if (skip) begin
                pc_next = skip_pc;
            end else begin
                pc_next = seq_pc;
            end
        end
    end

    // ---------------- Control registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= '0;
            sp    <= '0;
            fault <= FAULT_NONE;
        end else begin
            pc    <= pc_next;
            sp    <= sp_next;
            fault <= fault_next;
        end
    end

    // Return-address storage carries no reset: entries at or above sp are
    // never read, and reset clears sp.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

    localparam int PCW   = 10;
    localparam int DEPTH = 8;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           jump = 1'b0;
    logic           call = 1'b0;
    logic           ret = 1'b0;
    logic           skip = 1'b0;
    logic [PCW-1:0] target = '0;
    logic [PCW-1:0] pc;
    logic [SPW-1:0] sp;
    logic           stack_full;
    logic           stack_empty;
    logic           halted;
    logic [1:0]     fault;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference: pc as an integer, stack as a queue of
    // return addresses, sticky halt flag.
    int m_pc;
    int m_stack[$];
    int m_fault;
    bit m_halted;

    prog_counter #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .call(call),
        .ret(ret), .skip(skip), .target(target), .pc(pc), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_fault = 0;
        m_halted = 1'b0;
    endtask

    task automatic model_step(input bit e, j, c, r, s, input int t);
        if (m_halted || !e) return;
        if (r) begin
            if (m_stack.size() == 0) begin
                m_fault = 2; m_halted = 1'b1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (c) begin
            if (m_stack.size() == DEPTH) begin
                m_fault = 1; m_halted = 1'b1;
            end else begin
                m_stack.push_back((m_pc + 1) % (1 << PCW));
                m_pc = t;
            end
        end else if (j) begin
            m_pc = t;
        end else if (s) begin
            m_pc = (m_pc + 2) % (1 << PCW);
        end else begin
            m_pc = (m_pc + 1) % (1 << PCW);
        end
    endtask

    // One clock with the given request pattern; inputs change 1 time unit
    // after the edge so they are stable well before the next one.
    task automatic cycle(input logic e, j, c, r, s, input logic [PCW-1:0] t);
        en = e; jump = j; call = c; ret = r; skip = s; target = t;
        @(posedge clk);
        model_step(e, j, c, r, s, int'(t));
        #1;
        en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
    endtask

    task automatic do_reset(input logic e, j, c, r, s, input logic [PCW-1:0] t);
        rst_n = 1'b0;
        en = e; jump = j; call = c; ret = r; skip = s; target = t;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h123);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h040);
        // reset asserted together with a call request
        do_reset(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h055);
        n_cmp++;
        if (pc !== 10'h000) begin n_fail++; $display("FAIL reset_pc: got %h want 000", pc); end
        n_cmp++;
        if (sp !== 4'd0) begin n_fail++; $display("FAIL reset_sp: got %0d want 0", sp); end
        n_cmp++;
        if (fault !== 2'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_fault_halted: got %0d/%b want 0/0", fault, halted);
        end
        n_cmp++;
        if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", stack_empty, stack_full);
        end
    endtask

    task automatic test_sequential();
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            n_cmp++;
            if (pc !== PCW'(k) || sp !== 4'd0 || fault !== 2'd0) begin
                n_fail++;
                $display("FAIL seq_step%0d: pc=%h sp=%0d fault=%0d want pc=%h sp=0 fault=0",
                         k, pc, sp, fault, PCW'(k));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FE);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        n_cmp++;
        if (pc !== 10'h000) begin n_fail++; $display("FAIL wrap_skip: got %h want 000", pc); end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_cmp++;
        if (pc !== 10'h000) begin n_fail++; $display("FAIL wrap_seq: got %h want 000", pc); end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h010);
        n_cmp++;
        if (pc !== 10'h010 || sp !== 4'd1) begin
            n_fail++; $display("FAIL wrap_call: pc=%h sp=%0d want 010/1", pc, sp);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_cmp++;
        if (pc !== 10'h000 || sp !== 4'd0) begin
            n_fail++; $display("FAIL wrap_ret: pc=%h sp=%0d want 000/0", pc, sp);
        end
    endtask

    task automatic fill_stack();
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h020);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PCW'(10'h100 + k));
            n_cmp++;
            if (pc !== PCW'(10'h100 + k) || sp !== SPW'(k + 1)) begin
                n_fail++;
                $display("FAIL nest_call%0d: pc=%h sp=%0d want %h/%0d", k, pc, sp,
                         PCW'(10'h100 + k), k + 1);
            end
        end
        n_cmp++;
        if (stack_full !== 1'b1 || stack_empty !== 1'b0) begin
            n_fail++; $display("FAIL nest_full: full=%b empty=%b want 1/0", stack_full, stack_empty);
        end
    endtask

    task automatic test_nested();
        logic [PCW-1:0] exp_pc;
        fill_stack();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
            exp_pc = (i < DEPTH - 1) ? PCW'(10'h107 - i) : 10'h021;
            n_cmp++;
            if (pc !== exp_pc || sp !== SPW'(DEPTH - 1 - i)) begin
                n_fail++;
                $display("FAIL nest_ret%0d: pc=%h sp=%0d want %h/%0d", i, pc, sp, exp_pc,
                         DEPTH - 1 - i);
            end
        end
        n_cmp++;
        if (stack_empty !== 1'b1) begin n_fail++; $display("FAIL nest_empty: got %b want 1", stack_empty); end
    endtask

    task automatic test_overflow();
        fill_stack();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h200);
        n_cmp++;
        if (fault !== 2'd1 || halted !== 1'b1 || pc !== 10'h107 || sp !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow: fault=%0d halted=%b pc=%h sp=%0d want 1/1/107/8",
                     fault, halted, pc, sp);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h300);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_cmp++;
        if (fault !== 2'd1 || halted !== 1'b1 || pc !== 10'h107 || sp !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow_frozen: fault=%0d halted=%b pc=%h sp=%0d want 1/1/107/8",
                     fault, halted, pc, sp);
        end
        do_reset(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h2AA);
        n_cmp++;
        if (pc !== 10'h000 || fault !== 2'd0 || halted !== 1'b0 || sp !== 4'd0) begin
            n_fail++;
            $display("FAIL overflow_reset: pc=%h fault=%0d halted=%b sp=%0d want 000/0/0/0",
                     pc, fault, halted, sp);
        end
    endtask

    task automatic test_underflow();
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_cmp++;
        if (fault !== 2'd2 || halted !== 1'b1 || pc !== 10'h005 || sp !== 4'd0) begin
            n_fail++;
            $display("FAIL underflow: fault=%0d halted=%b pc=%h sp=%0d want 2/1/005/0",
                     fault, halted, pc, sp);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0AA);
        n_cmp++;
        if (fault !== 2'd2 || pc !== 10'h005 || sp !== 4'd0) begin
            n_fail++; $display("FAIL underflow_frozen: fault=%0d pc=%h sp=%0d want 2/005/0", fault, pc, sp);
        end
    endtask

    task automatic test_priority();
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h04F);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h077);   // pushes 0x050
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h3AA);
        n_cmp++;
        if (pc !== 10'h050 || sp !== 4'd0) begin
            n_fail++; $display("FAIL prio_ret: pc=%h sp=%0d want 050/0", pc, sp);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h123);
        n_cmp++;
        if (pc !== 10'h050 || sp !== 4'd0) begin
            n_fail++; $display("FAIL stall_call: pc=%h sp=%0d want 050/0", pc, sp);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h1AB);
        n_cmp++;
        if (pc !== 10'h1AB || fault !== 2'd0) begin
            n_fail++; $display("FAIL prio_jump_skip: pc=%h fault=%0d want 1AB/0", pc, fault);
        end
    endtask

    task automatic test_random();
        logic e, j, c, r, s;
        logic [PCW-1:0] t;
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int n = 0; n < 1500; n++) begin
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 4) == 0);
            s = ($urandom_range(0, 4) == 0);
            t = PCW'($urandom);
            if ($urandom_range(0, 39) == 0 || (m_halted && $urandom_range(0, 3) == 0))
                do_reset(e, j, c, r, s, t);
            else
                cycle(e, j, c, r, s, t);
            n_cmp++;
            if (pc !== PCW'(m_pc) || sp !== SPW'(m_stack.size()) || fault !== 2'(m_fault)
                || halted !== m_halted || stack_full !== (m_stack.size() == DEPTH)
                || stack_empty !== (m_stack.size() == 0)) begin
                n_fail++;
                $display("FAIL random%0d: pc=%h sp=%0d fault=%0d halted=%b full=%b empty=%b want pc=%h sp=%0d fault=%0d halted=%b",
                         n, pc, sp, fault, halted, stack_full, stack_empty,
                         PCW'(m_pc), m_stack.size(), m_fault, m_halted);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_wrap();
        test_nested();
        test_overflow();
        test_underflow();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
